// File: rtl/kapi_pkg.sv
// rtl/kapi_pkg.sv - shared types and constants for the kapi gate-block sweep engine
package kapi_pkg;

   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } kapi_state_t;

endpackage

// File: rtl/kapi_sat_sayac.sv
// rtl/kapi_sat_sayac.sv - W-bit saturating up counter with synchronous clear
module kapi_sat_sayac #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !(&cnt)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/kapi_tarayici.sv
// rtl/kapi_tarayici.sv - exhaustive input sweep and compare engine for combinational gate blocks
module kapi_tarayici
   import kapi_pkg::*;
#(
   parameter int N_IN       = 14,
   parameter int SETTLE_CYC = 2,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             dut_o_i,
   input  logic             exp_o_i,
   output logic [N_IN-1:0]  vec_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic [N_IN-1:0]  first_fail_o,
   output logic             ff_valid_o
);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

   kapi_state_t         state;
   kapi_state_t         state_nx;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                mismatch;
   logic                settle_end;
   logic                vec_last;
   logic                err_clr;
   logic                err_inc;

   assign mismatch   = dut_o_i ^ exp_o_i;
   assign settle_end = (settle_cnt == SETTLE_LAST);
   assign vec_last   = &vec_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (abort_i) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: if (start_i) state_nx = ST_SETTLE;
            ST_SETTLE:        if (settle_end) state_nx = ST_CHECK;
            ST_CHECK:         state_nx = vec_last ? ST_DONE : ST_SETTLE;
            default:          state_nx = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o  = (state == ST_SETTLE) || (state == ST_CHECK);
      done_o  = (state == ST_DONE);
      err_clr = !abort_i && start_i && ((state == ST_IDLE) || (state == ST_DONE));
      err_inc = !abort_i && (state == ST_CHECK) && mismatch;
   end

   // Abort keeps the error tally and first-fail capture so a stopped sweep can still be inspected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_o        <= '0;
         settle_cnt   <= '0;
         pass_o       <= 1'b0;
         first_fail_o <= '0;
         ff_valid_o   <= 1'b0;
      end else if (abort_i) begin
         vec_o      <= '0;
         settle_cnt <= '0;
         pass_o     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  vec_o        <= '0;
                  settle_cnt   <= '0;
                  pass_o       <= 1'b0;
                  first_fail_o <= '0;
                  ff_valid_o   <= 1'b0;
               end
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
            end
            ST_CHECK: begin
               if (mismatch && !ff_valid_o) begin
                  first_fail_o <= vec_o;
                  ff_valid_o   <= 1'b1;
               end
               // The last compare lands in the counter on the same edge, so fold it in here.
               if (vec_last) begin
                  pass_o <= (err_cnt_o == '0) && !mismatch;
               end else begin
                  vec_o      <= vec_o + 1'b1;
                  settle_cnt <= '0;
               end
            end
            default: begin
               settle_cnt <= '0;
            end
         endcase
      end
   end

   kapi_sat_sayac #(
      .W(ERR_W)
   ) u_err_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (err_clr),
      .inc  (err_inc),
      .cnt  (err_cnt_o)
   );

endmodule

// File: tb/tb_kapi_tarayici.sv
// tb/tb_kapi_tarayici.sv - scoreboard bench for kapi_tarayici with randomized fault masks
module tb_kapi_tarayici;

   localparam int N_IN        = 4;
   localparam int SETTLE_CYC  = 2;
   localparam int ERR_W       = 3;
   localparam int NVEC        = 1 << N_IN;
   localparam int SWEEP_EDGES = NVEC * (SETTLE_CYC + 1);
   localparam int ERR_MAX     = (1 << ERR_W) - 1;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             start_i = 1'b0;
   logic             abort_i = 1'b0;
   logic [N_IN-1:0]  vec_o;
   logic             busy_o;
   logic             done_o;
   logic             pass_o;
   logic [ERR_W-1:0] err_cnt_o;
   logic [N_IN-1:0]  first_fail_o;
   logic             ff_valid_o;

   logic [NVEC-1:0]  fault_mask = '0;
   logic [N_IN-1:0]  gate_key   = '0;
   logic             exp_o;
   logic             dut_o;

   assign exp_o = ^(vec_o & gate_key);
   assign dut_o = exp_o ^ fault_mask[vec_o];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int err;
      bit ffv;
      int ff;
      bit pass;
      int start_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   kapi_tarayici #(
      .N_IN      (N_IN),
      .SETTLE_CYC(SETTLE_CYC),
      .ERR_W     (ERR_W)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .dut_o_i     (dut_o),
      .exp_o_i     (exp_o),
      .vec_o       (vec_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .pass_o      (pass_o),
      .err_cnt_o   (err_cnt_o),
      .first_fail_o(first_fail_o),
      .ff_valid_o  (ff_valid_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: scores each finished sweep and the per-vector hold time.
   logic            prev_done = 1'b0;
   logic            prev_busy = 1'b0;
   logic [N_IN-1:0] prev_vec  = '0;
   int              run       = 0;

   always @(negedge clk) begin
      if (done_o && !prev_done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("latency", cyc - mon_e.start_cyc, SWEEP_EDGES);
            check("err_cnt", err_cnt_o, mon_e.err);
            check("ff_valid", ff_valid_o, mon_e.ffv);
            check("first_fail", first_fail_o, mon_e.ff);
            check("pass", pass_o, mon_e.pass);
         end
      end
      if (busy_o && prev_busy && vec_o != prev_vec) begin
         check("vec_hold", run, SETTLE_CYC + 1);
         check("vec_step", vec_o, prev_vec + 1'b1);
      end
      run       = (busy_o && prev_busy && vec_o == prev_vec) ? run + 1 : 1;
      prev_done = done_o;
      prev_busy = busy_o;
      prev_vec  = vec_o;
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_vec"}, vec_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_pass"}, pass_o, 0);
      check({tag, "_err"}, err_cnt_o, 0);
      check({tag, "_ff"}, first_fail_o, 0);
      check({tag, "_ffv"}, ff_valid_o, 0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done_o && n < SWEEP_EDGES + 20) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done_o, 1);
   endtask

   task automatic wait_vec(input logic [N_IN-1:0] v);
      int n = 0;
      while (vec_o !== v && n < SWEEP_EDGES + 20) begin
         @(negedge clk);
         n++;
      end
      check("wait_vec", vec_o, v);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic run_sweep(input logic [NVEC-1:0] mask, input logic [N_IN-1:0] key,
                            input bit extra_start);
      exp_t e;
      int   pc    = 0;
      int   ff    = 0;
      bit   found = 1'b0;
      fault_mask = mask;
      gate_key   = key;
      for (int v = 0; v < NVEC; v++) begin
         if (mask[v]) begin
            pc++;
            if (!found) begin
               ff    = v;
               found = 1'b1;
            end
         end
      end
      e.err       = (pc > ERR_MAX) ? ERR_MAX : pc;
      e.ffv       = found;
      e.ff        = ff;
      e.pass      = (pc == 0);
      e.start_cyc = cyc + 1;
      sb.push_back(e);
      pulse_start();
      check("start_busy", busy_o, 1);
      check("start_vec", vec_o, 0);
      check("start_done_clr", done_o, 0);
      check("start_pass_clr", pass_o, 0);
      check("start_err_clr", err_cnt_o, 0);
      check("start_ffv_clr", ff_valid_o, 0);
      check("start_ff_clr", first_fail_o, 0);
      if (extra_start) begin
         repeat ($urandom_range(3, 30)) @(negedge clk);
         pulse_start();
      end
      wait_done();
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_sweep('0, N_IN'($urandom), 1'b0);
      run_sweep(16'h0820, N_IN'($urandom), 1'b0);
      run_sweep(16'hFFFF, N_IN'($urandom), 1'b0);

      // Abort in the first SETTLE cycle of vector 7 after a fault at vector 5.
      fault_mask = 16'h0020;
      pulse_start();
      wait_vec(4'h7);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_vec", vec_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_done", done_o, 0);
      check("abort_pass", pass_o, 0);
      check("abort_err_kept", err_cnt_o, 1);
      check("abort_ffv_kept", ff_valid_o, 1);
      check("abort_ff_kept", first_fail_o, 5);
      start_i = 1'b1;
      abort_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      check("abort_wins_busy", busy_o, 0);
      check("abort_wins_err", err_cnt_o, 1);
      run_sweep('0, N_IN'($urandom), 1'b0);

      // Reset asserted during the CHECK cycle of vector 9.
      fault_mask = 16'h0006;
      pulse_start();
      wait_vec(4'h9);
      repeat (SETTLE_CYC) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("rst_mid");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_rel");

      run_sweep(16'h4001, N_IN'($urandom), 1'b1);
      for (int i = 0; i < 8; i++) begin
         run_sweep(NVEC'($urandom & $urandom & $urandom), N_IN'($urandom),
                   1'($urandom_range(0, 1)));
      end
      run_sweep('0, N_IN'($urandom), 1'b1);

      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
